// File: rtl/ode_mem_map_pkg.sv
// rtl/ode_mem_map_pkg.sv - shared ODE RAM map and euler_step_engine state encodings
package ode_mem_map_pkg;

   localparam int N_ADDR         = 0;
   localparam int M_ADDR         = 1;
   localparam int MODE_ADDR      = 2;
   localparam int TOL_ADDR       = 3;
   localparam int HTEMP_ADDR     = 4;
   localparam int HINIT_ADDR     = 5;
   localparam int X_PROCESS_BASE = 6;
   localparam int X_INIT_BASE    = 56;
   localparam int XN0_BASE       = 106;
   localparam int D_BASE         = 156;
   localparam int MAX_N_DEF      = 50;

   typedef logic [2:0] euler_state_t;

   localparam euler_state_t ST_IDLE  = 3'd0;
   localparam euler_state_t ST_HDR   = 3'd1;
   localparam euler_state_t ST_LATCH = 3'd2;
   localparam euler_state_t ST_ISSUE = 3'd3;
   localparam euler_state_t ST_MUL   = 3'd4;
   localparam euler_state_t ST_ADD   = 3'd5;
   localparam euler_state_t ST_WRITE = 3'd6;
   localparam euler_state_t ST_DONE  = 3'd7;

endpackage

// File: rtl/fxp_mul_add.sv
// rtl/fxp_mul_add.sv - combinational signed Q-format multiply and add
// EULER_SAT_EN: saturate both results to 16 bits and report overflow; otherwise wrap.
module fxp_mul_add #(
   parameter int FRAC_BITS = 8
) (
   input  logic [15:0] mul_a,
   input  logic [15:0] mul_b,
   input  logic [15:0] add_a,
   input  logic [15:0] add_b,
   output logic [15:0] prod,
   output logic [15:0] sum,
   output logic        prod_ovf,
   output logic        sum_ovf
);

`ifdef EULER_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   logic signed [31:0] a_ext;
   logic signed [31:0] b_ext;
   logic signed [31:0] prod_full;
   logic signed [31:0] prod_shift;
   logic        [16:0] sum_full;
   logic               prod_wide;
   logic               sum_wide;

   always_comb begin
      a_ext      = {{16{mul_a[15]}}, mul_a};
      b_ext      = {{16{mul_b[15]}}, mul_b};
      prod_full  = a_ext * b_ext;
      prod_shift = prod_full >>> FRAC_BITS;
      sum_full   = {add_a[15], add_a} + {add_b[15], add_b};
      // A result fits in 16 bits only when every dropped bit equals the new sign bit.
      prod_wide  = (prod_shift[31:15] != {17{prod_shift[15]}});
      sum_wide   = (sum_full[16] != sum_full[15]);
      prod_ovf   = SAT_EN & prod_wide;
      sum_ovf    = SAT_EN & sum_wide;
      if (prod_ovf) begin
         prod = prod_shift[31] ? 16'h8000 : 16'h7FFF;
      end else begin
         prod = prod_shift[15:0];
      end
      if (sum_ovf) begin
         sum = sum_full[16] ? 16'h8000 : 16'h7FFF;
      end else begin
         sum = sum_full[15:0];
      end
   end

endmodule

// File: rtl/euler_step_engine.sv
// rtl/euler_step_engine.sv - one explicit Euler update X_process = X_init + h*D over shared RAM
// EULER_SAT_EN selects saturating arithmetic and a live Euler_Overflow flag.
import ode_mem_map_pkg::*;

module euler_step_engine #(
   parameter int ADDRESS_WIDTH = 13,
   parameter int DATA_WIDTH    = 64,
   parameter int FRAC_BITS     = 8,
   parameter int MAX_N         = MAX_N_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     Euler_Enable,
   output logic                     Euler_End,
   output logic                     Euler_Overflow,
   output logic [ADDRESS_WIDTH-1:0] RAM_Address_RD_A,
   output logic [ADDRESS_WIDTH-1:0] RAM_Address_RD_B,
   input  logic [DATA_WIDTH-1:0]    RAM_Data_RD_A,
   input  logic [DATA_WIDTH-1:0]    RAM_Data_RD_B,
   output logic [ADDRESS_WIDTH-1:0] RAM_Address_WR,
   output logic [DATA_WIDTH-1:0]    RAM_Data_WR,
   output logic                     Euler_Memory_WR_Enable
);

   euler_state_t             state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] n_q, n_d;
   logic [ADDRESS_WIDTH-1:0] i_q, i_d;
   logic [15:0]              h_q, h_d;
   logic [15:0]              x_q, x_d;
   logic [15:0]              p_q, p_d;
   logic [15:0]              s_q, s_d;
   logic                     ovf_q, ovf_d;

   logic [12:0] n_raw;
   logic [12:0] n_clamp;
   logic [15:0] prod;
   logic [15:0] sum;
   logic        prod_ovf;
   logic        sum_ovf;
   logic        unused_rd_hi;

   assign unused_rd_hi = ^{RAM_Data_RD_A[DATA_WIDTH-1:16], RAM_Data_RD_B[DATA_WIDTH-1:16]};

   fxp_mul_add #(
      .FRAC_BITS (FRAC_BITS)
   ) u_fxp_mul_add (
      .mul_a    (h_q),
      .mul_b    (RAM_Data_RD_B[15:0]),
      .add_a    (x_q),
      .add_b    (p_q),
      .prod     (prod),
      .sum      (sum),
      .prod_ovf (prod_ovf),
      .sum_ovf  (sum_ovf)
   );

   always_comb begin
      n_raw   = RAM_Data_RD_A[12:0];
      n_clamp = (n_raw > 13'(MAX_N)) ? 13'(MAX_N) : n_raw;
      state_d = state_q;
      n_d     = n_q;
      i_d     = i_q;
      h_d     = h_q;
      x_d     = x_q;
      p_d     = p_q;
      s_d     = s_q;
      ovf_d   = ovf_q;
      case (state_q)
         ST_IDLE:  if (Euler_Enable) state_d = ST_HDR;
         ST_HDR:   state_d = ST_LATCH;
         ST_LATCH: begin
            h_d     = RAM_Data_RD_B[15:0];
            n_d     = ADDRESS_WIDTH'(n_clamp);
            i_d     = '0;
            ovf_d   = 1'b0;
            state_d = (n_clamp == 13'd0) ? ST_DONE : ST_ISSUE;
         end
         ST_ISSUE: state_d = ST_MUL;
         ST_MUL: begin
            x_d     = RAM_Data_RD_A[15:0];
            p_d     = prod;
            ovf_d   = ovf_q | prod_ovf;
            state_d = ST_ADD;
         end
         ST_ADD: begin
            s_d     = sum;
            ovf_d   = ovf_q | sum_ovf;
            state_d = ST_WRITE;
         end
         ST_WRITE: begin
            i_d     = i_q + ADDRESS_WIDTH'(1);
            state_d = ((i_q + ADDRESS_WIDTH'(1)) == n_q) ? ST_DONE : ST_ISSUE;
         end
         ST_DONE:  if (!Euler_Enable) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      // Losing the request mid-run abandons the vector; a WRITE in progress still strobes.
      if (!Euler_Enable && state_q != ST_IDLE && state_q != ST_DONE) begin
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         n_q     <= '0;
         i_q     <= '0;
         h_q     <= '0;
         x_q     <= '0;
         p_q     <= '0;
         s_q     <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         i_q     <= i_d;
         h_q     <= h_d;
         x_q     <= x_d;
         p_q     <= p_d;
         s_q     <= s_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      RAM_Address_RD_A       = '0;
      RAM_Address_RD_B       = '0;
      RAM_Address_WR         = '0;
      RAM_Data_WR            = '0;
      Euler_Memory_WR_Enable = 1'b0;
      if (state_q == ST_HDR) begin
         RAM_Address_RD_A = ADDRESS_WIDTH'(N_ADDR);
         RAM_Address_RD_B = ADDRESS_WIDTH'(HTEMP_ADDR);
      end else if (state_q == ST_ISSUE) begin
         RAM_Address_RD_A = ADDRESS_WIDTH'(X_INIT_BASE) + i_q;
         RAM_Address_RD_B = ADDRESS_WIDTH'(D_BASE) + i_q;
      end else if (state_q == ST_WRITE) begin
         RAM_Address_WR         = ADDRESS_WIDTH'(X_PROCESS_BASE) + i_q;
         RAM_Data_WR            = {{(DATA_WIDTH-16){s_q[15]}}, s_q};
         Euler_Memory_WR_Enable = 1'b1;
      end
      Euler_End      = (state_q == ST_DONE);
      Euler_Overflow = ovf_q;
   end

endmodule

// File: tb/tb_euler_step_engine.sv
// tb/tb_euler_step_engine.sv - directed self-checking bench for euler_step_engine
module tb_euler_step_engine;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        Euler_Enable;
   logic        Euler_End;
   logic        Euler_Overflow;
   logic [12:0] RAM_Address_RD_A;
   logic [12:0] RAM_Address_RD_B;
   logic [63:0] RAM_Data_RD_A;
   logic [63:0] RAM_Data_RD_B;
   logic [12:0] RAM_Address_WR;
   logic [63:0] RAM_Data_WR;
   logic        Euler_Memory_WR_Enable;

   logic [63:0] mem [0:255];
   logic [12:0] wr_addr_log [$];
   logic [63:0] wr_data_log [$];
   int          addr_viol = 0;
   int          checks = 0;
   int          failures = 0;

   euler_step_engine dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .Euler_Enable           (Euler_Enable),
      .Euler_End              (Euler_End),
      .Euler_Overflow         (Euler_Overflow),
      .RAM_Address_RD_A       (RAM_Address_RD_A),
      .RAM_Address_RD_B       (RAM_Address_RD_B),
      .RAM_Data_RD_A          (RAM_Data_RD_A),
      .RAM_Data_RD_B          (RAM_Data_RD_B),
      .RAM_Address_WR         (RAM_Address_WR),
      .RAM_Data_WR            (RAM_Data_WR),
      .Euler_Memory_WR_Enable (Euler_Memory_WR_Enable)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      RAM_Data_RD_A <= mem[RAM_Address_RD_A[7:0]];
      RAM_Data_RD_B <= mem[RAM_Address_RD_B[7:0]];
      if (Euler_Memory_WR_Enable) begin
         wr_addr_log.push_back(RAM_Address_WR);
         wr_data_log.push_back(RAM_Data_WR);
      end
      if (RAM_Address_RD_A >= 13'd206 || RAM_Address_RD_B >= 13'd206 || RAM_Address_WR >= 13'd206)
         addr_viol <= addr_viol + 1;
   end

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic start_run(input logic [12:0] n, input logic [15:0] h, output int base);
      mem[0] = {48'hABCD_0000_0000, 3'b000, n};
      mem[4] = {48'hDEAD_BEEF_0000, h};
      base = wr_addr_log.size();
      @(negedge clk);
      Euler_Enable = 1'b1;
   endtask

   task automatic wait_end(input int budget, output int lat);
      lat = 0;
      while (!Euler_End && lat < budget) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic end_run();
      Euler_Enable = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("end_released", {63'd0, Euler_End}, 64'd0);
   endtask

   int  base;
   int  lat;
   logic saw_end;

   initial begin
      for (int k = 0; k < 256; k++) mem[k] = 64'h5555_0000_0000_0000;
      rst_n        = 1'b0;
      Euler_Enable = 1'b0;
      @(negedge clk);
      check("rst_end", {63'd0, Euler_End}, 64'd0);
      check("rst_ovf", {63'd0, Euler_Overflow}, 64'd0);
      check("rst_wren", {63'd0, Euler_Memory_WR_Enable}, 64'd0);
      check("rst_addr", {25'd0, RAM_Address_RD_A, RAM_Address_RD_B, RAM_Address_WR}, 64'd0);
      check("rst_wdata", RAM_Data_WR, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // N=1: 0x0200 + 0.5*0x0100 = 0x0280
      mem[56]  = 64'hFFFF_0000_0000_0200;
      mem[156] = 64'h1234_0000_0000_0100;
      start_run(13'd1, 16'h0080, base);
      wait_end(50, lat);
      check("n1_latency", 64'(lat), 64'd7);
      check("n1_writes", 64'(wr_addr_log.size() - base), 64'd1);
      if (wr_addr_log.size() > base) begin
         check("n1_addr", 64'(wr_addr_log[base]), 64'd6);
         check("n1_data", wr_data_log[base], 64'h0000_0000_0000_0280);
      end
      end_run();

      // N=3, h=1.0
      mem[56] = 64'h0100; mem[57] = 64'hFF00; mem[58] = 64'h0;
      mem[156] = 64'h0100; mem[157] = 64'h0100; mem[158] = 64'hFE00;
      start_run(13'd3, 16'h0100, base);
      wait_end(100, lat);
      check("n3_latency", 64'(lat), 64'd15);
      check("n3_writes", 64'(wr_addr_log.size() - base), 64'd3);
      if (wr_addr_log.size() >= base + 3) begin
         check("n3_addr0", 64'(wr_addr_log[base]), 64'd6);
         check("n3_data0", wr_data_log[base], 64'h0000_0000_0000_0200);
         check("n3_addr1", 64'(wr_addr_log[base+1]), 64'd7);
         check("n3_data1", wr_data_log[base+1], 64'h0000_0000_0000_0000);
         check("n3_addr2", 64'(wr_addr_log[base+2]), 64'd8);
         check("n3_data2", wr_data_log[base+2], 64'hFFFF_FFFF_FFFF_FE00);
      end
      end_run();

      // 0x7F00 + 0x7F00 overflows 16 bits
      mem[56] = 64'h7F00; mem[156] = 64'h7F00;
      start_run(13'd1, 16'h0100, base);
      wait_end(50, lat);
      check("sat_writes", 64'(wr_addr_log.size() - base), 64'd1);
      if (wr_addr_log.size() > base) begin
`ifdef EULER_SAT_EN
         check("sat_data", wr_data_log[base], 64'h0000_0000_0000_7FFF);
`else
         check("sat_data", wr_data_log[base], 64'hFFFF_FFFF_FFFF_FE00);
`endif
      end
`ifdef EULER_SAT_EN
      check("sat_ovf", {63'd0, Euler_Overflow}, 64'd1);
`else
      check("sat_ovf", {63'd0, Euler_Overflow}, 64'd0);
`endif
      end_run();

      // N=0 finishes without writes and clears the overflow flag at LATCH
      start_run(13'd0, 16'h0100, base);
      wait_end(50, lat);
      check("n0_latency", 64'(lat), 64'd3);
      check("n0_writes", 64'(wr_addr_log.size() - base), 64'd0);
      check("n0_ovf", {63'd0, Euler_Overflow}, 64'd0);
      end_run();

      // N=60 clamps to 50
      for (int k = 0; k < 50; k++) begin
         mem[56+k]  = 64'(k);
         mem[156+k] = 64'h0100;
      end
      start_run(13'd60, 16'h0100, base);
      wait_end(400, lat);
      check("n60_latency", 64'(lat), 64'd203);
      check("n60_writes", 64'(wr_addr_log.size() - base), 64'd50);
      if (wr_addr_log.size() >= base + 50) begin
         check("n60_last_addr", 64'(wr_addr_log[base+49]), 64'd55);
         check("n60_last_data", wr_data_log[base+49], 64'h0131);
      end
      end_run();

      // Abort: drop enable in cycle 6 (WRITE of element 0) of an N=4 run
      mem[56] = 64'h0100; mem[57] = 64'h0; mem[58] = 64'h0; mem[59] = 64'h0;
      mem[156] = 64'h0100; mem[157] = 64'h0; mem[158] = 64'h0; mem[159] = 64'h0;
      start_run(13'd4, 16'h0100, base);
      repeat (6) @(negedge clk);
      Euler_Enable = 1'b0;
      @(negedge clk);
      check("abort_idle_wren", {63'd0, Euler_Memory_WR_Enable}, 64'd0);
      check("abort_idle_rdaddr", {51'd0, RAM_Address_RD_A}, 64'd0);
      saw_end = 1'b0;
      repeat (10) begin
         @(negedge clk);
         saw_end = saw_end | Euler_End;
      end
      check("abort_no_end", {63'd0, saw_end}, 64'd0);
      check("abort_writes", 64'(wr_addr_log.size() - base), 64'd1);
      if (wr_addr_log.size() > base) check("abort_data", wr_data_log[base], 64'h0200);

      // Asynchronous reset while the first write strobe is up
      start_run(13'd4, 16'h0100, base);
      repeat (6) @(negedge clk);
      check("pre_rst_wren", {63'd0, Euler_Memory_WR_Enable}, 64'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_wren", {63'd0, Euler_Memory_WR_Enable}, 64'd0);
      check("mid_rst_addr", {25'd0, RAM_Address_RD_A, RAM_Address_RD_B, RAM_Address_WR}, 64'd0);
      check("mid_rst_wdata", RAM_Data_WR, 64'd0);
      check("mid_rst_end", {63'd0, Euler_End}, 64'd0);
      @(negedge clk);
      check("mid_rst_writes", 64'(wr_addr_log.size() - base), 64'd0);
      Euler_Enable = 1'b0;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      check("addr_range", 64'(addr_viol), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
